ram_port_arbiter: RTL and testbench

//  Shares the single-port 32x8 synchronous RAM (lpm, registered address/data/wren,

---
 rtl/ram_port_arbiter.sv | 109 ++++++++++
 tb/tb_ram_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester arbiter that owns all control pins of one synchronous single-port RAM
module ram_port_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t state, state_d;
  logic owner, owner_d, last_owner, last_owner_d, win_b;
  logic a_gnt_d, a_ack_d, b_gnt_d, b_ack_d, wren_d, busy_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] data_d, a_rdata_d, b_rdata_d;
  // next-state and next-output decode; owner 0 = A, 1 = B, and ram_wren doubles as the latched we in ISSUE
  always_comb begin
    win_b = (a_req && b_req) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_owner) : b_req;
    state_d = state;
    owner_d = owner;
    last_owner_d = last_owner;
    address_d = ram_address;
    data_d = ram_data;
    wren_d = 1'b0;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    a_rdata_d = a_rdata;
    b_rdata_d = b_rdata;
    case (state)
      IDLE: if (a_req || b_req) begin
        owner_d = win_b;
        last_owner_d = win_b;
        address_d = win_b ? b_addr : a_addr;
        data_d = win_b ? b_wdata : a_wdata;
        wren_d = win_b ? b_we : a_we;
        a_gnt_d = ~win_b;
        b_gnt_d = win_b;
        state_d = ISSUE;
      end
      ISSUE: begin
        a_ack_d = ram_wren && !owner;
        b_ack_d = ram_wren && owner;
        state_d = ram_wren ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        a_ack_d = ~owner;
        b_ack_d = owner;
        a_rdata_d = owner ? a_rdata : ram_q;
        b_rdata_d = owner ? ram_q : b_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // register every output; last_owner resets to B so A wins the first tie
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= 1'b0;
      last_owner <= 1'b1;
      ram_address <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      last_owner <= last_owner_d;
      ram_address <= address_d;
      ram_data <= data_d;
      ram_wren <= wren_d;
      a_gnt <= a_gnt_d;
      b_gnt <= b_gnt_d;
      a_ack <= a_ack_d;
      b_ack <= b_ack_d;
      a_rdata <= a_rdata_d;
      b_rdata <= b_rdata_d;
      busy <= busy_d;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter in round-robin and fixed-priority builds
module tb_ram_port_arbiter;
  typedef struct {logic we; logic [4:0] addr; logic [7:0] d;} cmd_t;
  logic clock = 1'b0, resetn;
  logic a_req, a_we, a_gnt, a_ack, b_req, b_we, b_gnt, b_ack, ram_wren, busy;
  logic [4:0] a_addr, b_addr, ram_address, ra0;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_data, ram_q;
  logic f_a_req, f_a_we, f_a_gnt, f_a_ack, f_b_req, f_b_we, f_b_gnt, f_b_ack, f_ram_wren, f_busy;
  logic [4:0] f_a_addr, f_b_addr, f_ram_address, fra;
  logic [7:0] f_a_wdata, f_b_wdata, f_a_rdata, f_b_rdata, f_ram_data, f_ram_q;
  logic [7:0] mem0 [32];
  logic [7:0] ref_mem [32];
  cmd_t cmd_a[$], cmd_b[$], qa[$], qb[$];
  int ack_order[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int a_req_cyc, a_gnt_cyc, b_req_cyc, b_gnt_cyc, b_ack_cyc;
  int wren_cnt = 0, a_gnt_cnt = 0, b_gnt_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0;
  int f_a_gnt_cnt = 0, f_b_gnt_cnt = 0, f_b_ack_cnt = 0;
  logic [7:0] a_last, b_last;

  ram_port_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(0)) dut (
    .clock(clock), .resetn(resetn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy)
  );

  ram_port_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(1)) u_fp (
    .clock(clock), .resetn(resetn),
    .a_req(f_a_req), .a_we(f_a_we), .a_addr(f_a_addr), .a_wdata(f_a_wdata),
    .a_gnt(f_a_gnt), .a_ack(f_a_ack), .a_rdata(f_a_rdata),
    .b_req(f_b_req), .b_we(f_b_we), .b_addr(f_b_addr), .b_wdata(f_b_wdata),
    .b_gnt(f_b_gnt), .b_ack(f_b_ack), .b_rdata(f_b_rdata),
    .ram_address(f_ram_address), .ram_data(f_ram_data), .ram_wren(f_ram_wren),
    .ram_q(f_ram_q), .busy(f_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren) mem0[ram_address] <= ram_data;
    ra0 <= ram_address;
    fra <= f_ram_address;
  end
  assign ram_q = mem0[ra0];
  assign f_ram_q = {3'b000, fra} ^ 8'hC3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic put_a(input logic we, input logic [4:0] ad, input logic [7:0] d);
    cmd_a.push_back('{we, ad, d});
    qa.push_back('{we, ad, we ? d : ref_mem[ad]});
    if (we) ref_mem[ad] = d;
  endtask

  task automatic put_b(input logic we, input logic [4:0] ad, input logic [7:0] d);
    cmd_b.push_back('{we, ad, d});
    qb.push_back('{we, ad, we ? d : ref_mem[ad]});
    if (we) ref_mem[ad] = d;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((cmd_a.size() != 0 || cmd_b.size() != 0 || qa.size() != 0 || qb.size() != 0 ||
            busy || a_req || b_req) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // requester agents and scoreboard monitor, all on the falling edge
  initial begin
    cmd_t e;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    a_last = 0; b_last = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!resetn) begin a_last = 0; b_last = 0; end
      if (ram_wren) wren_cnt++;
      if (a_gnt || b_gnt || a_ack || b_ack)
        chk("gnt_ack_exclusive", {a_gnt && b_gnt, a_ack && b_ack, a_gnt && a_ack, b_gnt && b_ack}, 0);
      if (a_gnt) begin a_gnt_cyc = cyc; a_gnt_cnt++; end
      if (b_gnt) begin b_gnt_cyc = cyc; b_gnt_cnt++; end
      if (a_ack) begin
        a_ack_cnt++;
        ack_order.push_back(0);
        chk("a_ack_expected", qa.size() != 0, 1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("a_latency", cyc - a_gnt_cyc, e.we ? 1 : 2);
          if (!e.we) begin chk("a_rdata", a_rdata, e.d); a_last = e.d; end
          chk("a_ack_b_rdata_hold", b_rdata, b_last);
        end
      end
      if (b_ack) begin
        b_ack_cnt++;
        b_ack_cyc = cyc;
        ack_order.push_back(1);
        chk("b_ack_expected", qb.size() != 0, 1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("b_latency", cyc - b_gnt_cyc, e.we ? 1 : 2);
          if (!e.we) begin chk("b_rdata", b_rdata, e.d); b_last = e.d; end
          chk("b_ack_a_rdata_hold", a_rdata, a_last);
        end
      end
      if (f_a_gnt) f_a_gnt_cnt++;
      if (f_b_gnt) f_b_gnt_cnt++;
      if (f_a_ack) chk("fp_a_rdata", f_a_rdata, 8'hC7);
      if (f_b_ack) begin f_b_ack_cnt++; chk("fp_b_rdata", f_b_rdata, 8'hCA); end
      if (a_req && a_gnt) begin
        void'(cmd_a.pop_front());
        if (cmd_a.size() != 0) begin a_we = cmd_a[0].we; a_addr = cmd_a[0].addr; a_wdata = cmd_a[0].d; end
        else a_req = 0;
      end else if (!a_req && cmd_a.size() != 0) begin
        a_we = cmd_a[0].we; a_addr = cmd_a[0].addr; a_wdata = cmd_a[0].d;
        a_req = 1; a_req_cyc = cyc;
      end
      if (b_req && b_gnt) begin
        void'(cmd_b.pop_front());
        if (cmd_b.size() != 0) begin b_we = cmd_b[0].we; b_addr = cmd_b[0].addr; b_wdata = cmd_b[0].d; end
        else b_req = 0;
      end else if (!b_req && cmd_b.size() != 0) begin
        b_we = cmd_b[0].we; b_addr = cmd_b[0].addr; b_wdata = cmd_b[0].d;
        b_req = 1; b_req_cyc = cyc;
      end
    end
  end

  // directed sequence
  initial begin
    int w0, g0, g1, k0, o, n;
    resetn = 0;
    f_a_req = 0; f_a_we = 0; f_a_addr = 0; f_a_wdata = 0;
    f_b_req = 0; f_b_we = 0; f_b_addr = 0; f_b_wdata = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ctl", {a_gnt, a_ack, b_gnt, b_ack, ram_wren, busy}, 0);
    chk("rst_ram_bus", {ram_address, ram_data}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    resetn = 1;
    @(posedge clock); #1;
    w0 = wren_cnt; g0 = b_gnt_cnt; k0 = b_ack_cnt;
    put_a(1, 5'd3, 8'h5A);
    wait_idle("t1_done", 20);
    chk("t1_gnt_latency", a_gnt_cyc - a_req_cyc, 1);
    chk("t1_wren_cycles", wren_cnt - w0, 1);
    chk("t1_b_idle", (b_gnt_cnt - g0) + (b_ack_cnt - k0), 0);
    put_b(0, 5'd3, 8'h00);
    wait_idle("t2_done", 20);
    chk("t2_ack_latency", b_ack_cyc - b_req_cyc, 3);
    chk("t2_b_rdata", b_rdata, 8'h5A);
    chk("t2_a_rdata_hold", a_rdata, 8'h00);
    o = ack_order.size();
    repeat (4) begin put_a(0, 5'd3, 8'h00); put_b(0, 5'd3, 8'h00); end
    wait_idle("t3_done", 60);
    for (int i = 0; i < 8; i++) chk("t3_rr_order", ack_order[o + i], i % 2);
    put_a(1, 5'd7, 8'h77);
    wait_idle("t3_wr_done", 20);
    o = ack_order.size();
    put_a(0, 5'd7, 8'h00); put_b(0, 5'd7, 8'h00);
    wait_idle("t3_tie_done", 20);
    chk("t3_b_first", ack_order[o], 1);
    chk("t3_a_second", ack_order[o + 1], 0);
    g0 = f_a_gnt_cnt; g1 = f_b_gnt_cnt; k0 = f_b_ack_cnt;
    f_a_addr = 5'd4; f_a_req = 1; f_b_addr = 5'd9; f_b_req = 1;
    repeat (30) begin @(posedge clock); #1; end
    chk("t4_a_gnts", f_a_gnt_cnt - g0, 10);
    chk("t4_b_blocked", f_b_gnt_cnt - g1, 0);
    f_a_req = 0;
    n = 0;
    while (f_b_gnt_cnt == g1 && n < 8) begin @(posedge clock); #1; n++; end
    f_b_req = 0;
    chk("t4_b_served", f_b_gnt_cnt - g1, 1);
    repeat (4) begin @(posedge clock); #1; end
    chk("t4_b_ack", f_b_ack_cnt - k0, 1);
    chk("t4_a_gnts_final", f_a_gnt_cnt - g0, 10);
    for (int i = 0; i < 32; i++) put_b(1, 5'(i), 8'(i) ^ 8'hFF);
    wait_idle("t5_fill", 200);
    for (int i = 0; i < 32; i++) put_a(0, 5'(i), 8'h00);
    wait_idle("t5_read", 200);
    chk("t5_addr31", a_rdata, 8'hE0);
    g0 = a_gnt_cnt; k0 = a_ack_cnt;
    put_a(0, 5'd3, 8'h00);
    n = 0;
    while (a_gnt_cnt == g0 && n < 10) begin @(posedge clock); #1; n++; end
    chk("t6_gnt_seen", a_gnt_cnt - g0, 1);
    resetn = 0;
    #1;
    qa.delete();
    chk("t6_busy", busy, 0);
    chk("t6_a_rdata", a_rdata, 8'h00);
    chk("t6_a_ack", a_ack, 0);
    repeat (2) begin @(posedge clock); #1; end
    chk("t6_no_ack", a_ack_cnt - k0, 0);
    resetn = 1;
    put_a(0, 5'd3, 8'h00);
    wait_idle("t6_after_done", 20);
    chk("t6_after_rdata", a_rdata, 8'hFC);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
